// File: rtl/drv_ce_pkg.sv
// Shared types and default sizing for the CPU clock-enable generator.
// The state enum and helper are used by drv_ce_gen.
package drv_ce_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam int DEF_PHASES  = 8;
    localparam int DEF_AUX_DIV = 2;
    localparam int DEF_CNT_W   = 32;

    // A divide-by-one aux counter still needs one bit so its compare stays legal.
    function automatic int aux_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/drv_ce_gen.sv
// CPU phase/clock-enable generator: derives phi2 edge pulses, a divided aux enable
// and a completed-cycle count from a base ce, with pause-at-boundary and turbo.
module drv_ce_gen
    import drv_ce_pkg::*;
#(
    parameter int PHASES  = DEF_PHASES,
    parameter int AUX_DIV = DEF_AUX_DIV,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      pause_req,
    input  logic                      turbo,
    output logic                      p2_h_r,
    output logic                      p2_h_f,
    output logic                      aux_ce,
    output logic                      paused,
    output logic [$clog2(PHASES)-1:0] phase,
    output logic [CNT_W-1:0]          cyc_cnt
);

    localparam int                PH_W  = $clog2(PHASES);
    localparam int                AUX_W = aux_width(AUX_DIV);
    localparam logic [PH_W-1:0]   HALF  = PH_W'(PHASES / 2);
    localparam logic [AUX_W-1:0]  AUX_LAST = AUX_W'(AUX_DIV - 1);

    state_t             state_q;
    state_t             state_d;
    logic [PH_W-1:0]    phase_q;
    logic [PH_W-1:0]    phase_d;
    logic [AUX_W-1:0]   aux_cnt_q;
    logic [AUX_W-1:0]   aux_cnt_d;
    logic               turbo_q;
    logic               turbo_d;
    logic [CNT_W-1:0]   cyc_q;
    logic [CNT_W-1:0]   cyc_d;
    logic               p2_h_r_d;
    logic               p2_h_f_d;
    logic               aux_ce_d;
    logic               paused_d;

    logic               at_top;
    logic               at_mid;
    logic               halt_cycle;
    logic               step_go;
    logic [PH_W-1:0]    step;

    // The block is always at phase 0 while halted, so a single rule covers both
    // states: a ce at phase 0 with pause_req halts, any other ce is a running step.
    assign at_top     = (phase_q == '0);
    assign at_mid     = (phase_q == HALF);
    assign halt_cycle = at_top && pause_req;
    assign step_go    = ce && !halt_cycle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            phase_q   <= '0;
            aux_cnt_q <= '0;
            turbo_q   <= 1'b0;
            cyc_q     <= '0;
            p2_h_r    <= 1'b0;
            p2_h_f    <= 1'b0;
            aux_ce    <= 1'b0;
            paused    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            aux_cnt_q <= aux_cnt_d;
            turbo_q   <= turbo_d;
            cyc_q     <= cyc_d;
            p2_h_r    <= p2_h_r_d;
            p2_h_f    <= p2_h_f_d;
            aux_ce    <= aux_ce_d;
            paused    <= paused_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ce) begin
            state_d = halt_cycle ? HALT : RUN;
        end
    end

    // Turbo is latched at the cycle boundary and applied to that same step, so the
    // counter only ever visits even phases in turbo and still hits 0 and PHASES/2.
    always_comb begin
        phase_d   = phase_q;
        aux_cnt_d = aux_cnt_q;
        turbo_d   = turbo_q;
        cyc_d     = cyc_q;
        step      = PH_W'(1);
        if (step_go) begin
            if (at_top) begin
                turbo_d = turbo;
            end
            step    = turbo_d ? PH_W'(2) : PH_W'(1);
            phase_d = phase_q + step;
            aux_cnt_d = (aux_cnt_q == AUX_LAST) ? '0 : aux_cnt_q + AUX_W'(1);
            if (at_mid) begin
                cyc_d = cyc_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        p2_h_r_d = step_go && at_top;
        p2_h_f_d = step_go && at_mid;
        aux_ce_d = step_go && (aux_cnt_q == AUX_LAST);
        paused_d = (state_d == HALT);
    end

    assign phase   = phase_q;
    assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_drv_ce_gen.sv
// Self-checking bench for drv_ce_gen: a cycle-level behavioural model compared
// every clock, plus hand-computed literal checkpoints for each scenario.
module tb_drv_ce_gen;

    localparam int PHASES  = 8;
    localparam int AUX_DIV = 2;
    localparam int CNT_W   = 32;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      ce = 1'b0;
    logic                      pause_req = 1'b0;
    logic                      turbo = 1'b0;
    logic                      p2_h_r;
    logic                      p2_h_f;
    logic                      aux_ce;
    logic                      paused;
    logic [$clog2(PHASES)-1:0] phase;
    logic [CNT_W-1:0]          cyc_cnt;

    int checks = 0;
    int failures = 0;
    int n_r = 0;
    int n_f = 0;
    int n_aux = 0;

    int     m_phase = 0;
    int     m_aux = 0;
    bit     m_turbo = 0;
    bit     m_halt = 0;
    longint m_cyc = 0;
    bit     e_r = 0;
    bit     e_f = 0;
    bit     e_aux = 0;
    bit     model_valid = 0;

    drv_ce_gen #(
        .PHASES (PHASES),
        .AUX_DIV(AUX_DIV),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .pause_req(pause_req),
        .turbo    (turbo),
        .p2_h_r   (p2_h_r),
        .p2_h_f   (p2_h_f),
        .aux_ce   (aux_ce),
        .paused   (paused),
        .phase    (phase),
        .cyc_cnt  (cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model works per CPU cycle rules: a ce at the boundary with pause_req parks
    // the CPU, every other ce is one running step of the phase wheel.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_aux = 0; m_turbo = 0; m_halt = 0; m_cyc = 0;
            e_r = 0; e_f = 0; e_aux = 0;
            model_valid = 1;
        end else begin
            e_r = 0; e_f = 0; e_aux = 0;
            if (ce) begin
                if (m_phase == 0 && pause_req) begin
                    m_halt = 1;
                end else begin
                    m_halt = 0;
                    if (m_phase == 0) begin
                        e_r = 1;
                        m_turbo = turbo;
                    end
                    if (m_phase == PHASES / 2) begin
                        e_f = 1;
                        m_cyc = (m_cyc + 1) % (64'd1 << CNT_W);
                    end
                    m_aux = (m_aux + 1) % AUX_DIV;
                    if (m_aux == 0) e_aux = 1;
                    m_phase = (m_phase + (m_turbo ? 2 : 1)) % PHASES;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("p2_h_r", 64'(p2_h_r), 64'(e_r));
            checkOutput("p2_h_f", 64'(p2_h_f), 64'(e_f));
            checkOutput("aux_ce", 64'(aux_ce), 64'(e_aux));
            checkOutput("paused", 64'(paused), 64'(m_halt));
            checkOutput("phase", 64'(phase), 64'(m_phase));
            checkOutput("cyc_cnt", 64'(cyc_cnt), 64'(m_cyc));
        end
    end

    task automatic applyStimulus(input logic r, input logic c, input logic p, input logic t);
        @(negedge clk);
        reset = r; ce = c; pause_req = p; turbo = t;
        @(posedge clk);
        #1;
        n_r   += (p2_h_r === 1'b1) ? 1 : 0;
        n_f   += (p2_h_f === 1'b1) ? 1 : 0;
        n_aux += (aux_ce === 1'b1) ? 1 : 0;
    endtask

    task automatic runCycles(input int n, input logic p, input logic t);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, p, t);
    endtask

    task automatic clearCounts();
        n_r = 0; n_f = 0; n_aux = 0;
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_phase", 64'(phase), 64'd0);
        checkOutput("reset_cyc", 64'(cyc_cnt), 64'd0);
        checkOutput("reset_paused", 64'(paused), 64'd0);

        // Scenario 1: ce every clk, 80 clk
        clearCounts();
        runCycles(80, 1'b0, 1'b0);
        checkOutput("s1_cyc", 64'(cyc_cnt), 64'd10);
        checkOutput("s1_n_r", 64'(n_r), 64'd10);
        checkOutput("s1_n_f", 64'(n_f), 64'd10);
        checkOutput("s1_n_aux", 64'(n_aux), 64'd40);

        // Scenario 2: ce every other clk, pulses stay one clk wide
        clearCounts();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("s2_n_r", 64'(n_r), 64'd2);
        checkOutput("s2_n_aux", 64'(n_aux), 64'd8);
        checkOutput("s2_cyc", 64'(cyc_cnt), 64'd12);

        // Scenario 3: pause raised at phase 3
        runCycles(3, 1'b0, 1'b0);
        checkOutput("s3_phase3", 64'(phase), 64'd3);
        clearCounts();
        runCycles(5, 1'b1, 1'b0);
        checkOutput("s3_n_f", 64'(n_f), 64'd1);
        checkOutput("s3_wrap_phase", 64'(phase), 64'd0);
        checkOutput("s3_not_yet_paused", 64'(paused), 64'd0);
        runCycles(1, 1'b1, 1'b0);
        checkOutput("s3_paused", 64'(paused), 64'd1);
        checkOutput("s3_no_r", 64'(p2_h_r), 64'd0);
        clearCounts();
        runCycles(5, 1'b1, 1'b0);
        checkOutput("s3_halt_pulses", 64'(n_r + n_f + n_aux), 64'd0);
        checkOutput("s3_cyc_frozen", 64'(cyc_cnt), 64'd13);

        // Scenario 4: resume
        runCycles(1, 1'b0, 1'b0);
        checkOutput("s4_paused", 64'(paused), 64'd0);
        checkOutput("s4_r", 64'(p2_h_r), 64'd1);
        checkOutput("s4_phase1", 64'(phase), 64'd1);
        runCycles(1, 1'b0, 1'b0);
        checkOutput("s4_phase2", 64'(phase), 64'd2);

        // Scenario 5: turbo raised at phase 5
        runCycles(3, 1'b0, 1'b0);
        checkOutput("s5_phase5", 64'(phase), 64'd5);
        runCycles(3, 1'b0, 1'b1);
        checkOutput("s5_step1_to_0", 64'(phase), 64'd0);
        clearCounts();
        runCycles(16, 1'b0, 1'b1);
        checkOutput("s5_n_r", 64'(n_r), 64'd4);
        checkOutput("s5_n_aux", 64'(n_aux), 64'd8);
        checkOutput("s5_cyc", 64'(cyc_cnt), 64'd18);

        // Scenario 6: reset while halted at cyc_cnt 0x20
        runCycles(56, 1'b0, 1'b1);
        runCycles(1, 1'b1, 1'b1);
        checkOutput("s6_halted", 64'(paused), 64'd1);
        checkOutput("s6_cyc20", 64'(cyc_cnt), 64'h20);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("s6_rst_paused", 64'(paused), 64'd0);
        checkOutput("s6_rst_cyc", 64'(cyc_cnt), 64'd0);
        checkOutput("s6_rst_phase", 64'(phase), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s6_idle_no_r", 64'(p2_h_r), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_first_r", 64'(p2_h_r), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_phase2_step1", 64'(phase), 64'd2);

        // A ce at phase 0 coinciding with reset must not produce a pulse
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_suppress_r", 64'(p2_h_r), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
